// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Frame: 4-byte big-endian length, payload, XOR checksum byte.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int WORD_BITS  = 32;
    localparam int BYTE_BITS  = 8;
    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = WORD_BITS / BYTE_BITS;

endpackage

// File: rtl/instr_loader.sv
// Boot loader: packs a framed byte stream into big-endian words, writes them
// to instruction memory and releases the core only after a verified load.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int BYTE_SIZE = 8,
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] FIRST_INSTR_ADDR = 32'hBFC00000,
    parameter logic [DATA_WIDTH-1:0] LAST_INSTR_ADDR = 32'hBFC00FFF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  byte_valid_i,
    input  logic [BYTE_SIZE-1:0]  byte_i,
    output logic                  byte_ready_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  cpu_rst_n_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] HDR_LAST = DATA_WIDTH'(HDR_BYTES - 1);
    localparam logic [1:0] WORD_LAST = 2'(WORD_BYTES - 1);
    localparam logic [DATA_WIDTH-1:0] MAX_LEN =
        LAST_INSTR_ADDR - FIRST_INSTR_ADDR + ONE;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] len;
    logic [DATA_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] word_buf;
    logic [BYTE_SIZE-1:0]  csum;

    logic [DATA_WIDTH-1:0] len_next;
    logic [DATA_WIDTH-1:0] word_next;
    logic                  len_ok;
    logic                  accept;

    assign busy_o       = (state == HDR) || (state == DATA) || (state == CSUM);
    assign byte_ready_o = busy_o;
    assign done_o       = (state == DONE);
    assign cpu_rst_n_o  = (state == DONE);
    assign error_o      = (state == ERR);

    assign accept    = byte_valid_i && byte_ready_o;
    assign len_next  = {len[DATA_WIDTH-BYTE_SIZE-1:0], byte_i};
    assign word_next = {word_buf[DATA_WIDTH-BYTE_SIZE-1:0], byte_i};
    // Length must be non-zero, whole words, and fit the instruction region.
    assign len_ok    = (len_next != '0) && (len_next[1:0] == 2'b00) &&
                       (len_next <= MAX_LEN);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start_i) state_next = HDR;
            end
            HDR: begin
                if (accept && cnt == HDR_LAST)
                    state_next = len_ok ? DATA : ERR;
            end
            DATA: begin
                if (accept && (cnt + ONE) == len) state_next = CSUM;
            end
            CSUM: begin
                if (accept) state_next = (byte_i == csum) ? DONE : ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            len         <= '0;
            cnt         <= '0;
            word_buf    <= '0;
            csum        <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            mem_we_o <= 1'b0;
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        len      <= '0;
                        cnt      <= '0;
                        word_buf <= '0;
                        csum     <= '0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        len <= len_next;
                        cnt <= (cnt == HDR_LAST) ? '0 : cnt + ONE;
                    end
                end
                DATA: begin
                    if (accept) begin
                        word_buf <= word_next;
                        csum     <= csum ^ byte_i;
                        cnt      <= cnt + ONE;
                        if (cnt[1:0] == WORD_LAST) begin
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= FIRST_INSTR_ADDR +
                                           {cnt[DATA_WIDTH-1:2], 2'b00};
                            mem_wdata_o <= word_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader; expected memory writes are queued as each
// frame is built and matched against the write port as writes appear.
module tb_instr_loader;

    localparam logic [31:0] FIRST = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        bvalid = 1'b0;
    logic [7:0]  bdata = 8'h00;
    logic        ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;
    int writes = 0;
    logic [31:0] last_addr = '0;
    logic        prev_we = 1'b0;

    logic [63:0] sb[$];
    logic [7:0]  frame[$];
    logic [7:0]  pay[$];

    instr_loader dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .start_i(start),
        .byte_valid_i(bvalid),
        .byte_i(bdata),
        .byte_ready_o(ready),
        .mem_we_o(mem_we),
        .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata),
        .cpu_rst_n_o(cpu_rst_n),
        .busy_o(busy),
        .done_o(done),
        .error_o(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [63:0] exp;
        if (mem_we) begin
            writes++;
            last_addr = mem_addr;
            checks++;
            assert (prev_we === 1'b0) else begin
                errors++;
                $error("FAIL we_one_cycle got=%b exp=0", prev_we);
            end
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write got=%h:%h exp=none",
                       mem_addr, mem_wdata);
            end
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                checks++;
                assert ({mem_addr, mem_wdata} === exp) else begin
                    errors++;
                    $error("FAIL write got=%h:%h exp=%h:%h",
                           mem_addr, mem_wdata, exp[63:32], exp[31:0]);
                end
            end
        end
        prev_we = mem_we;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit st,
                             input bit stall);
        int n;
        n = 0;
        @(negedge clk);
        if (stall) begin
            bvalid = 1'b0;
            start = 1'b0;
            @(negedge clk);
        end
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (ready === 1'b1) else begin
            errors++;
            $error("FAIL ready_timeout got=%b exp=1", ready);
        end
        start = st;
        bvalid = 1'b1;
        bdata = b;
        @(posedge clk);
    endtask

    task automatic send_frame(input bit stall, input int start_at);
        for (int i = 0; i < frame.size(); i++)
            send_byte(frame[i], i == start_at, stall);
        @(negedge clk);
        bvalid = 1'b0;
        start = 1'b0;
    endtask

    task automatic build(input logic [31:0] len, input logic [7:0] cs_xor,
                         input bit with_words);
        logic [7:0] cs;
        cs = 8'h00;
        frame.delete();
        for (int i = 3; i >= 0; i--) frame.push_back(len[i*8 +: 8]);
        foreach (pay[i]) begin
            frame.push_back(pay[i]);
            cs ^= pay[i];
        end
        if (pay.size() > 0) frame.push_back(cs ^ cs_xor);
        if (with_words)
            for (int i = 0; i + 3 < pay.size(); i += 4)
                sb.push_back({FIRST + 32'(i),
                              pay[i], pay[i+1], pay[i+2], pay[i+3]});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic good_payload();
        pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    endtask

    task automatic chk_done(input string tag, input int exp_writes);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'd1);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        chk({tag, "_writes"}, 64'(writes), 64'(exp_writes));
    endtask

    task automatic chk_err(input string tag, input int exp_writes);
        chk({tag, "_error"}, 64'(error), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'd0);
        chk({tag, "_writes"}, 64'(writes), 64'(exp_writes));
    endtask

    initial begin
        int base;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready", 64'(ready), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        // Good load
        pulse_start();
        chk("start_busy", 64'(busy), 64'd1);
        good_payload();
        build(32'd8, 8'h00, 1'b1);
        chk("good_csum_byte", 64'(frame[12]), 64'h26);
        send_frame(1'b0, -1);
        chk_done("good", 2);

        // Restart from DONE drops the core reset
        pulse_start();
        chk("restart_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);

        // Bad checksum
        build(32'd8, 8'h01, 1'b1);
        send_frame(1'b0, -1);
        chk_err("badcs", 4);

        // Bad lengths
        pay.delete();
        pulse_start();
        chk("errclr_error", 64'(error), 64'd0);
        build(32'd6, 8'h00, 1'b0);
        send_frame(1'b0, -1);
        chk_err("len6", 4);
        pulse_start();
        build(32'h1004, 8'h00, 1'b0);
        send_frame(1'b0, -1);
        chk_err("len1004", 4);
        pulse_start();
        build(32'd0, 8'h00, 1'b0);
        send_frame(1'b0, -1);
        chk_err("len0", 4);

        // Stalled stream
        pulse_start();
        good_payload();
        build(32'd8, 8'h00, 1'b1);
        send_frame(1'b1, -1);
        chk_done("stall", 6);

        // start_i during DATA is ignored
        pulse_start();
        build(32'd8, 8'h00, 1'b1);
        send_frame(1'b0, 6);
        chk_done("startdata", 8);

        // Full region load
        pulse_start();
        pay.delete();
        for (int i = 0; i < 4096; i++) pay.push_back(8'($urandom));
        build(32'd4096, 8'h00, 1'b1);
        send_frame(1'b0, -1);
        chk_done("full", 8 + 1024);
        chk("full_last_addr", 64'(last_addr), 64'hBFC00FFC);

        // Reset mid-load after 6 payload bytes
        base = writes;
        pulse_start();
        good_payload();
        build(32'd8, 8'h00, 1'b0);
        sb.push_back({FIRST, 32'hDEADBEEF});
        for (int i = 0; i < 10; i++) send_byte(frame[i], 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_we", 64'(mem_we), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bdata = 8'h03;
        repeat (10) @(negedge clk);
        bvalid = 1'b0;
        chk("midrst_writes", 64'(writes), 64'(base + 1));
        chk("midrst_sb_empty", 64'(sb.size()), 64'd0);
        chk("midrst_idle_busy", 64'(busy), 64'd0);
        chk("midrst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader on the writer side of the instruction memory. It accepts a framed byte stream over a valid/ready interface and packs the bytes into 32-bit big-endian instruction words. It writes each word into the instruction memory image starting at `FIRST_INSTR_ADDR`, and holds the core in reset until a complete, checksum-verified program has been written.

## Interface
Parameters:
- `BYTE_SIZE`, 8: width of one stream byte and one memory byte.
- `DATA_WIDTH`, 32: instruction word and address width.
- `FIRST_INSTR_ADDR`, 32'hBFC00000: address of the first instruction word.
- `LAST_INSTR_ADDR`, 32'hBFC00FFF: last valid byte address of the instruction region (region size 4096 bytes).

Ports:
- `clk_i`  in  1: single clock, rising-edge.
- `rst_n_i`  in  1: asynchronous, active-low reset.
- `start_i`  in  1: one-cycle pulse that begins a load.
- `byte_valid_i`  in  1: stream byte present.
- `byte_i`  in  BYTE_SIZE: stream byte.
- `byte_ready_o`  out  1: loader can accept a byte.
- `mem_we_o`  out  1: word write strobe.
- `mem_addr_o`  out  DATA_WIDTH: word-aligned write address.
- `mem_wdata_o`  out  DATA_WIDTH: word data. `[31:24]` is the byte at `addr+0`.
- `cpu_rst_n_o`  out  1: active-low core reset; 1 only after a successful load.
- `busy_o`  out  1: high in HDR, DATA and CSUM.
- `done_o`  out  1: last load succeeded.
- `error_o`  out  1: last load failed.

## Operation
- Frame format: 4-byte length L (MSB first), then L payload bytes, then 1 checksum byte. The checksum is the XOR of all payload bytes.
- A byte is accepted on a rising edge where `byte_valid_i && byte_ready_o`.
- `byte_ready_o` is a function of state only: 1 in HDR, DATA and CSUM; 0 otherwise.
- States:
  - IDLE: `start_i` -> HDR. The transition clears the length, byte counter, word buffer and checksum.
  - HDR: shift accepted bytes into L, MSB first. After the 4th byte:
    - L == 0, L[1:0] != 0, or L > LAST_INSTR_ADDR-FIRST_INSTR_ADDR+1 -> ERR.
    - Otherwise -> DATA.
  - DATA:
    - Each accepted byte is shifted into the word buffer (first byte ends up in `[31:24]`) and XORed into the checksum.
    - On every 4th byte, issue a word write to `FIRST_INSTR_ADDR + 4*word_index`.
    - When the accepted byte count equals L -> CSUM.
  - CSUM: accept 1 byte. If it equals the running XOR -> DONE, else -> ERR.
  - DONE: `done_o`=1, `cpu_rst_n_o`=1. `start_i` -> HDR, which drops `cpu_rst_n_o` to 0 and `done_o` to 0.
  - ERR: `error_o`=1, `cpu_rst_n_o`=0. `start_i` -> HDR, which clears `error_o`.
- `start_i` is ignored in HDR, DATA and CSUM.
- Words already written before an error are not rolled back; the core stays in reset regardless.
- Arithmetic: the byte counter and L are DATA_WIDTH bits wide. The address is computed as FIRST_INSTR_ADDR plus the byte offset with bits [1:0] forced to 0. No wrap-around past LAST_INSTR_ADDR is possible because of the HDR length check.

## Timing
- Reset values: state IDLE; `byte_ready_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `cpu_rst_n_o`=0, `busy_o`=0, `done_o`=0, `error_o`=0.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- Write latency: `mem_we_o` is high for exactly one cycle, the cycle after the edge that accepts a word's 4th byte. `mem_addr_o` and `mem_wdata_o` are valid in that same cycle and hold until the next write.
- The last word's write occurs in the first cycle of CSUM. It therefore always precedes DONE, even with back-to-back valid bytes.
- DONE/ERR outputs assert the cycle after the deciding byte is accepted. `cpu_rst_n_o` rises in the same cycle as `done_o`.
- Throughput: one byte per cycle when `byte_valid_i` is held high. Gaps in valid stall without side effects.
- Asserting `rst_n_i` mid-load returns to IDLE immediately:
  - Any pending write is dropped.
  - `mem_we_o` falls asynchronously.

## Structure
- Package `instr_loader_pkg` holds:
  - the state enum (IDLE, HDR, DATA, CSUM, DONE, ERR);
  - `HDR_BYTES`=4;
  - `WORD_BYTES`=DATA_WIDTH/BYTE_SIZE.
- No sub-module: the byte packer, counters and checksum are inline in a single FSM module.

## Test plan
- Reset: hold `rst_n_i`=0 -> all outputs 0 and `byte_ready_o`=0. After release, IDLE with no activity.
- Good load: `start_i`, then stream 00 00 00 08, DE AD BE EF 01 02 03 04, 26 ->
  - one-cycle writes 0xDEADBEEF @ 0xBFC00000 and 0x01020304 @ 0xBFC00004;
  - then `done_o`=1 and `cpu_rst_n_o`=1.
- Bad checksum: same frame with checksum 27 -> both words are written, then `error_o`=1, `cpu_rst_n_o`=0 and `done_o`=0.
- Bad length:
  - header 00 00 00 06 -> ERR after the 4th header byte, with no write.
  - header 00 00 10 04 -> ERR.
  - header 00 00 00 00 -> ERR.
- Stall/ignore:
  - The good-load frame with `byte_valid_i` toggling every cycle gives identical writes and DONE.
  - `start_i` pulsed during DATA has no effect.
  - `start_i` in DONE restarts, and `cpu_rst_n_o` drops to 0.
- Boundary/reset: a full 4096-byte load writes its last word at 0xBFC00FFC and then DONE. Asserting `rst_n_i` after 6 payload bytes -> IDLE with no further `mem_we_o` pulses.
